// File: rtl/operand_pingpong_bank.sv
// Double-buffered A/B operand store: the back bank fills from the element stream
// while the front bank streams one row of A and one column of B per cycle.
//
// state      | meaning
// ST_IDLE    | waiting for rd_start with a full front bank
// ST_STREAM  | presenting beats 0..DIM-1 of the front bank
module operand_pingpong_bank #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DIM        = 4,
    localparam int CNT_W      = $clog2(DIM*DIM+1),
    localparam int IDX_W      = $clog2(DIM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic                      ld_sel,
    input  logic [DATA_WIDTH-1:0]     ld_data,
    input  logic                      rd_start,
    output logic                      rd_ready,
    input  logic                      tr_a,
    output logic                      rd_valid,
    output logic [IDX_W-1:0]          rd_idx,
    output logic [DIM*DATA_WIDTH-1:0] row_a,
    output logic [DIM*DATA_WIDTH-1:0] col_b,
    output logic                      rd_done,
    output logic                      err_ovf
);

    localparam int ADDR_W = $clog2(DIM*DIM);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIM*DIM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM-1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [DATA_WIDTH-1:0] mem_a_q [2][DIM*DIM];
    logic [DATA_WIDTH-1:0] mem_b_q [2][DIM*DIM];

    logic [0:0]              state_q, state_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    front_valid_q, front_valid_d;
    logic                    back_full_q, back_full_d;
    logic [CNT_W-1:0]        cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]        cnt_b_q, cnt_b_d;
    logic                    err_ovf_q, err_ovf_d;
    logic                    tr_q, tr_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_done_q, rd_done_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [DIM*DATA_WIDTH-1:0] row_a_q, row_a_d;
    logic [DIM*DATA_WIDTH-1:0] col_b_q, col_b_d;

    logic                    ld_acc, wr_a, wr_b, swap, rd_go, last_beat, front;
    logic [IDX_W-1:0]        beat_k;
    logic                    beat_tr;
    logic [DIM*DATA_WIDTH-1:0] beat_row, beat_col;

    assign ld_ready  = !back_full_q;
    assign rd_ready  = front_valid_q && (state_q == ST_IDLE);
    assign ld_acc    = ld_valid && !back_full_q;
    assign wr_a      = ld_acc && !ld_sel && (cnt_a_q != FULL_CNT);
    assign wr_b      = ld_acc &&  ld_sel && (cnt_b_q != FULL_CNT);
    assign swap      = back_full_q && !front_valid_q;
    assign rd_go     = rd_start && rd_ready;
    assign last_beat = (state_q == ST_STREAM) && (k_q == LAST_IDX);
    assign front     = ~wr_bank_q;

    // Beat 0 uses the live tr_a because it is launched on the same edge that latches it.
    assign beat_k  = (state_q == ST_IDLE) ? '0 : k_q + IDX_W'(1);
    assign beat_tr = (state_q == ST_IDLE) ? tr_a : tr_q;

    always_comb begin
        logic [ADDR_W-1:0] a_addr;
        logic [ADDR_W-1:0] b_addr;
        a_addr   = '0;
        b_addr   = '0;
        beat_row = '0;
        beat_col = '0;
        for (int j = 0; j < DIM; j++) begin
            a_addr = beat_tr ? ADDR_W'(j) * ADDR_W'(DIM) + ADDR_W'(beat_k)
                             : ADDR_W'(beat_k) * ADDR_W'(DIM) + ADDR_W'(j);
            b_addr = ADDR_W'(j) * ADDR_W'(DIM) + ADDR_W'(beat_k);
            beat_row[j*DATA_WIDTH +: DATA_WIDTH] = mem_a_q[front][a_addr];
            beat_col[j*DATA_WIDTH +: DATA_WIDTH] = mem_b_q[front][b_addr];
        end
    end

    always_comb begin
        cnt_a_d       = cnt_a_q;
        cnt_b_d       = cnt_b_q;
        back_full_d   = back_full_q;
        wr_bank_d     = wr_bank_q;
        front_valid_d = front_valid_q;
        err_ovf_d     = err_ovf_q;
        if (wr_a) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (wr_b) cnt_b_d = cnt_b_q + CNT_W'(1);
        if (ld_acc && !wr_a && !wr_b) err_ovf_d = 1'b1;
        if (ld_acc && (cnt_a_d == FULL_CNT) && (cnt_b_d == FULL_CNT)) back_full_d = 1'b1;
        if (swap) begin
            wr_bank_d     = ~wr_bank_q;
            front_valid_d = 1'b1;
            back_full_d   = 1'b0;
            cnt_a_d       = '0;
            cnt_b_d       = '0;
        end
        if (last_beat) front_valid_d = 1'b0;
    end

    always_comb begin
        logic beat_en;
        beat_en    = 1'b0;
        state_d    = state_q;
        k_d        = k_q;
        tr_d       = tr_q;
        rd_valid_d = rd_valid_q;
        rd_done_d  = rd_done_q;
        rd_idx_d   = rd_idx_q;
        row_a_d    = row_a_q;
        col_b_d    = col_b_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_go) begin
                    state_d = ST_STREAM;
                    tr_d    = tr_a;
                    beat_en = 1'b1;
                end
            end
            default: begin
                if (last_beat) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                    rd_done_d  = 1'b0;
                end else begin
                    beat_en = 1'b1;
                end
            end
        endcase
        if (beat_en) begin
            k_d        = beat_k;
            rd_valid_d = 1'b1;
            rd_idx_d   = beat_k;
            rd_done_d  = (beat_k == LAST_IDX);
            row_a_d    = beat_row;
            col_b_d    = beat_col;
        end
    end

    // Operand storage is intentionally not reset; a bank is only read after a full load.
    always_ff @(posedge clk) begin
        if (wr_a) mem_a_q[wr_bank_q][cnt_a_q[ADDR_W-1:0]] <= ld_data;
        if (wr_b) mem_b_q[wr_bank_q][cnt_b_q[ADDR_W-1:0]] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_bank_q     <= 1'b0;
            front_valid_q <= 1'b0;
            back_full_q   <= 1'b0;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            err_ovf_q     <= 1'b0;
            tr_q          <= 1'b0;
            k_q           <= '0;
            rd_valid_q    <= 1'b0;
            rd_done_q     <= 1'b0;
            rd_idx_q      <= '0;
            row_a_q       <= '0;
            col_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            front_valid_q <= front_valid_d;
            back_full_q   <= back_full_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
            err_ovf_q     <= err_ovf_d;
            tr_q          <= tr_d;
            k_q           <= k_d;
            rd_valid_q    <= rd_valid_d;
            rd_done_q     <= rd_done_d;
            rd_idx_q      <= rd_idx_d;
            row_a_q       <= row_a_d;
            col_b_q       <= col_b_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_done  = rd_done_q;
    assign rd_idx   = rd_idx_q;
    assign row_a    = row_a_q;
    assign col_b    = col_b_q;
    assign err_ovf  = err_ovf_q;

endmodule
